// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0]  NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned  DEFAULT_XLEN = 64;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds valid/pc/instr toward decode.
// Flush beats load, and load beats consume.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    input  logic            consume,
    input  logic            flush,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (consume) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, request/ack fetch FSM with redirect draining, and the IF/ID register.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            slot_free;
    logic            load, consume, flush;

    assign slot_free = !id_valid || id_ready;
    assign imem_addr = pc & ALIGN_MASK;

    always_comb begin
        imem_req = 1'b1;
        if (state == S_REQ) begin
            imem_req = slot_free && !redirect_valid && !reset;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        consume    = id_valid && id_ready;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_next = redirect_pc & ALIGN_MASK;
            // An in-flight request must still be acked before fetching the target.
            case (state)
                S_WAIT, S_DRAIN: state_next = imem_ack ? S_REQ : S_DRAIN;
                default:         state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            load    = 1'b1;
                            pc_next = pc + XLEN'(4);
                        end else begin
                            state_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        load       = 1'b1;
                        pc_next    = pc + XLEN'(4);
                        state_next = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    if_id_register #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_pc   (pc),
        .load_instr(imem_rdata),
        .consume   (consume),
        .flush     (flush),
        .valid     (id_valid),
        .pc        (id_pc),
        .instr     (id_instr)
    );

endmodule
